// File: rtl/vmu_page_swapper_pkg.sv
// Shared definitions for the VMU page swapper slice.
//   tPADDR          : 3-bit physical page index (8 physical pages)
//   PAGE0..PAGE7    : named physical page indices
//   tSTATE          : swapper FSM state encoding
//   *_DEF           : default parameter values used by the swapper and page table
package vmu_page_swapper_pkg;

    localparam int unsigned VPN_W_DEF      = 8;
    localparam int unsigned PAGE_WORDS_DEF = 64;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned NUM_PAGES      = 8;

    typedef logic [2:0] tPADDR;

    localparam tPADDR PAGE0 = 3'd0;
    localparam tPADDR PAGE1 = 3'd1;
    localparam tPADDR PAGE2 = 3'd2;
    localparam tPADDR PAGE3 = 3'd3;
    localparam tPADDR PAGE4 = 3'd4;
    localparam tPADDR PAGE5 = 3'd5;
    localparam tPADDR PAGE6 = 3'd6;
    localparam tPADDR PAGE7 = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB_RD = 3'd1,
        ST_WB_WR = 3'd2,
        ST_FILL  = 3'd3,
        ST_UPD   = 3'd4,
        ST_ACK   = 3'd5
    } tSTATE;

endpackage

// File: rtl/vmu_page_table.sv
// 8-entry physical page map: VPN tag, valid and dirty bit per physical page.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset (clears valid/dirty)
//   iLookupVpn                 VPN to look up
//   oHit, oHitIdx              combinational hit flag and matching physical page
//   iRdIdx                     entry to read out (combinational)
//   oRdTag, oRdValid, oRdDirty contents of entry iRdIdx
//   iUpdEn, iUpdIdx, iUpdTag,  install entry: tag, valid=1, dirty
//   iUpdDirty
//   iSetDirty, iSetDirtyIdx    mark an existing entry dirty (store hit)
module vmu_page_table
    import vmu_page_swapper_pkg::*;
#(
    parameter int unsigned VPN_W = VPN_W_DEF
)
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic [VPN_W-1:0] iLookupVpn,
    output logic             oHit,
    output tPADDR            oHitIdx,
    input  tPADDR            iRdIdx,
    output logic [VPN_W-1:0] oRdTag,
    output logic             oRdValid,
    output logic             oRdDirty,
    input  logic             iUpdEn,
    input  tPADDR            iUpdIdx,
    input  logic [VPN_W-1:0] iUpdTag,
    input  logic             iUpdDirty,
    input  logic             iSetDirty,
    input  tPADDR            iSetDirtyIdx
);

    logic [VPN_W-1:0]     r_tag [NUM_PAGES];
    logic [NUM_PAGES-1:0] r_valid;
    logic [NUM_PAGES-1:0] r_dirty;

    logic  w_hit;
    tPADDR w_hitIdx;

    // Only valid entries may match; tags are unique among valid entries.
    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = PAGE0;
        for (int unsigned i = 0; i < NUM_PAGES; i++) begin
            if (r_valid[i] && (r_tag[i] == iLookupVpn)) begin
                w_hit    = 1'b1;
                w_hitIdx = tPADDR'(i);
            end
        end
    end

    assign oHit     = w_hit;
    assign oHitIdx  = w_hitIdx;
    assign oRdTag   = r_tag[iRdIdx];
    assign oRdValid = r_valid[iRdIdx];
    assign oRdDirty = r_dirty[iRdIdx];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int unsigned i = 0; i < NUM_PAGES; i++) begin
                r_tag[i] <= '0;
            end
        end else if (iUpdEn) begin
            r_tag[iUpdIdx]   <= iUpdTag;
            r_valid[iUpdIdx] <= 1'b1;
            r_dirty[iUpdIdx] <= iUpdDirty;
        end else if (iSetDirty) begin
            r_dirty[iSetDirtyIdx] <= 1'b1;
        end
    end

endmodule

// File: rtl/vmu_page_swapper.sv
// Requester side of the LRU page tracker. Resolves virtual page requests
// against the 8-entry page map; on a miss evicts the LRU victim (writing it
// back to backing store if dirty) and fills the page from backing store.
// Every completed request reports the touched page to the LRU block.
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   iReq, iVpn, iWr        translation request (held until oAck), VPN, store flag
//   oAck, oPpn             1-cycle completion pulse with physical page
//   iLRU_PAddr             current LRU victim page
//   oLRU_PAddr, oLRU_WEnb  page touch report, coincident with oAck
//   oPm_Addr/WEnb/WData    physical memory port {page,word}
//   iPm_RData              physical memory read data, 1-cycle latency
//   oBs_Req/Write/Addr/    backing store request (held until iBs_Ack),
//   WData                  address {vpn,word}, write data
//   iBs_Ack, iBs_RData     backing store ack and read data
module vmu_page_swapper
    import vmu_page_swapper_pkg::*;
#(
    parameter int unsigned VPN_W      = VPN_W_DEF,
    parameter int unsigned PAGE_WORDS = PAGE_WORDS_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF
)
(
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 iReq,
    input  logic [VPN_W-1:0]                     iVpn,
    input  logic                                 iWr,
    output logic                                 oAck,
    output tPADDR                                oPpn,
    input  tPADDR                                iLRU_PAddr,
    output tPADDR                                oLRU_PAddr,
    output logic                                 oLRU_WEnb,
    output logic [3+$clog2(PAGE_WORDS)-1:0]      oPm_Addr,
    output logic                                 oPm_WEnb,
    output logic [DATA_W-1:0]                    oPm_WData,
    input  logic [DATA_W-1:0]                    iPm_RData,
    output logic                                 oBs_Req,
    output logic                                 oBs_Write,
    output logic [VPN_W+$clog2(PAGE_WORDS)-1:0]  oBs_Addr,
    output logic [DATA_W-1:0]                    oBs_WData,
    input  logic                                 iBs_Ack,
    input  logic [DATA_W-1:0]                    iBs_RData
);

    localparam int unsigned      CNT_W     = $clog2(PAGE_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(PAGE_WORDS - 1);

    tSTATE            r_state;
    tSTATE            w_nextState;
    logic [CNT_W-1:0] r_cnt;
    tPADDR            r_victim;
    tPADDR            r_ackPpn;
    logic [DATA_W-1:0] r_wbData;
    logic             r_wbLoad;

    logic             w_hit;
    tPADDR            w_hitIdx;
    tPADDR            w_rdIdx;
    logic [VPN_W-1:0] w_rdTag;
    logic             w_rdValid;
    logic             w_rdDirty;
    logic             w_last;
    logic             w_updEn;
    logic             w_setDirty;

    // In IDLE the victim candidate is the live LRU input; afterwards the latched one.
    assign w_rdIdx    = (r_state == ST_IDLE) ? iLRU_PAddr : r_victim;
    assign w_last     = (r_cnt == LAST_WORD);
    assign w_updEn    = (r_state == ST_UPD);
    assign w_setDirty = (r_state == ST_IDLE) && iReq && w_hit && iWr;

    vmu_page_table #(
        .VPN_W (VPN_W)
    ) u_table (
        .Clk          (Clk),
        .Reset        (Reset),
        .iLookupVpn   (iVpn),
        .oHit         (w_hit),
        .oHitIdx      (w_hitIdx),
        .iRdIdx       (w_rdIdx),
        .oRdTag       (w_rdTag),
        .oRdValid     (w_rdValid),
        .oRdDirty     (w_rdDirty),
        .iUpdEn       (w_updEn),
        .iUpdIdx      (r_victim),
        .iUpdTag      (iVpn),
        .iUpdDirty    (iWr),
        .iSetDirty    (w_setDirty),
        .iSetDirtyIdx (w_hitIdx)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        oAck        = 1'b0;
        oPpn        = PAGE0;
        oLRU_PAddr  = PAGE0;
        oLRU_WEnb   = 1'b0;
        oPm_Addr    = '0;
        oPm_WEnb    = 1'b0;
        oPm_WData   = '0;
        oBs_Req     = 1'b0;
        oBs_Write   = 1'b0;
        oBs_Addr    = '0;
        oBs_WData   = '0;
        case (r_state)
            ST_IDLE: begin
                if (iReq) begin
                    if (w_hit) begin
                        w_nextState = ST_ACK;
                    end else if (w_rdValid && w_rdDirty) begin
                        w_nextState = ST_WB_RD;
                    end else begin
                        w_nextState = ST_FILL;
                    end
                end
            end
            ST_WB_RD: begin
                oPm_Addr    = {r_victim, r_cnt};
                w_nextState = ST_WB_WR;
            end
            ST_WB_WR: begin
                oBs_Req   = 1'b1;
                oBs_Write = 1'b1;
                oBs_Addr  = {w_rdTag, r_cnt};
                // Read data is live only in the first WB_WR cycle; later cycles
                // of a stalled write use the captured copy.
                oBs_WData = r_wbLoad ? iPm_RData : r_wbData;
                if (iBs_Ack) begin
                    w_nextState = w_last ? ST_FILL : ST_WB_RD;
                end
            end
            ST_FILL: begin
                oBs_Req  = 1'b1;
                oBs_Addr = {iVpn, r_cnt};
                if (iBs_Ack) begin
                    oPm_WEnb    = 1'b1;
                    oPm_Addr    = {r_victim, r_cnt};
                    oPm_WData   = iBs_RData;
                    w_nextState = w_last ? ST_UPD : ST_FILL;
                end
            end
            ST_UPD: begin
                w_nextState = ST_ACK;
            end
            ST_ACK: begin
                oAck        = 1'b1;
                oPpn        = r_ackPpn;
                oLRU_PAddr  = r_ackPpn;
                oLRU_WEnb   = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_victim <= PAGE0;
            r_ackPpn <= PAGE0;
            r_wbData <= '0;
            r_wbLoad <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iReq) begin
                        r_cnt <= '0;
                        if (w_hit) begin
                            r_ackPpn <= w_hitIdx;
                        end else begin
                            r_victim <= iLRU_PAddr;
                        end
                    end
                end
                ST_WB_RD: begin
                    r_wbLoad <= 1'b1;
                end
                ST_WB_WR: begin
                    if (r_wbLoad) begin
                        r_wbData <= iPm_RData;
                        r_wbLoad <= 1'b0;
                    end
                    if (iBs_Ack) begin
                        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                ST_FILL: begin
                    if (iBs_Ack) begin
                        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                    end
                end
                ST_UPD: begin
                    r_ackPpn <= r_victim;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmu_page_swapper.sv
module tb_vmu_page_swapper;
    import vmu_page_swapper_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        iReq;
    logic [7:0]  iVpn;
    logic        iWr;
    logic        oAck;
    tPADDR       oPpn;
    tPADDR       iLRU_PAddr;
    tPADDR       oLRU_PAddr;
    logic        oLRU_WEnb;
    logic [8:0]  oPm_Addr;
    logic        oPm_WEnb;
    logic [31:0] oPm_WData;
    logic [31:0] iPm_RData;
    logic        oBs_Req;
    logic        oBs_Write;
    logic [13:0] oBs_Addr;
    logic [31:0] oBs_WData;
    logic        iBs_Ack;
    logic [31:0] iBs_RData;

    vmu_page_swapper #(
        .VPN_W      (8),
        .PAGE_WORDS (64),
        .DATA_W     (32)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .iReq       (iReq),
        .iVpn       (iVpn),
        .iWr        (iWr),
        .oAck       (oAck),
        .oPpn       (oPpn),
        .iLRU_PAddr (iLRU_PAddr),
        .oLRU_PAddr (oLRU_PAddr),
        .oLRU_WEnb  (oLRU_WEnb),
        .oPm_Addr   (oPm_Addr),
        .oPm_WEnb   (oPm_WEnb),
        .oPm_WData  (oPm_WData),
        .iPm_RData  (iPm_RData),
        .oBs_Req    (oBs_Req),
        .oBs_Write  (oBs_Write),
        .oBs_Addr   (oBs_Addr),
        .oBs_WData  (oBs_WData),
        .iBs_Ack    (iBs_Ack),
        .iBs_RData  (iBs_RData)
    );

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Backing store content for word w of page vpn.
    function automatic logic [31:0] bs_word(input logic [7:0] vpn, input logic [5:0] w);
        return {16'hB5A0, vpn, 2'b00, w};
    endfunction

    // Physical memory model: 1-cycle synchronous read.
    logic [31:0] pm [512];
    initial begin
        for (int i = 0; i < 512; i++) pm[i] = 32'hDEAD0000 | i;
    end
    always @(posedge Clk) begin
        if (oPm_WEnb) pm[oPm_Addr] <= oPm_WData;
        iPm_RData <= pm[oPm_Addr];
    end

    // Backing store responder: random ack delay, logs every acked transfer,
    // counts any change of a pending request before its ack.
    logic [13:0] bs_addr_q [$];
    logic        bs_wr_q   [$];
    logic [31:0] bs_wd_q   [$];
    int          bs_unstable = 0;
    int          bs_max_delay = 0;

    initial begin
        logic        pend;
        logic [13:0] p_addr;
        logic        p_wr;
        logic [31:0] p_wd;
        int          wait_left;
        pend = 1'b0; p_addr = '0; p_wr = 1'b0; p_wd = '0; wait_left = 0;
        iBs_Ack = 1'b0;
        iBs_RData = '0;
        forever begin
            @(posedge Clk); #1;
            iBs_Ack = 1'b0;
            if (Reset) begin
                pend = 1'b0;
            end else if (oBs_Req) begin
                if (!pend) begin
                    pend = 1'b1;
                    p_addr = oBs_Addr;
                    p_wr = oBs_Write;
                    p_wd = oBs_WData;
                    wait_left = $urandom_range(bs_max_delay, 0);
                end else if (oBs_Addr !== p_addr || oBs_Write !== p_wr ||
                             (p_wr && oBs_WData !== p_wd)) begin
                    bs_unstable++;
                end
                if (wait_left == 0) begin
                    iBs_Ack = 1'b1;
                    iBs_RData = p_wr ? 32'h0 : bs_word(p_addr[13:6], p_addr[5:0]);
                    bs_addr_q.push_back(p_addr);
                    bs_wr_q.push_back(p_wr);
                    bs_wd_q.push_back(p_wd);
                    pend = 1'b0;
                end else begin
                    wait_left--;
                end
            end else if (pend) begin
                bs_unstable++;
                pend = 1'b0;
            end
        end
    end

    task automatic clear_log();
        bs_addr_q.delete();
        bs_wr_q.delete();
        bs_wd_q.delete();
        bs_unstable = 0;
    endtask

    // Drives one request and waits (bounded) for oAck; entered and left at posedge+1.
    task automatic do_req(input logic [7:0] vpn, input logic wr, input tPADDR lru,
                          output int lat, output logic timeout, output tPADDR ppn,
                          output tPADDR lru_pa, output logic lru_we, output logic ack_after);
        lat = 0; timeout = 1'b1; ppn = PAGE0; lru_pa = PAGE0; lru_we = 1'b0;
        iVpn = vpn; iWr = wr; iLRU_PAddr = lru; iReq = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge Clk); #1;
            if (oAck) begin
                lat = c; timeout = 1'b0; ppn = oPpn; lru_pa = oLRU_PAddr; lru_we = oLRU_WEnb;
                break;
            end
        end
        iReq = 1'b0; iWr = 1'b0;
        @(posedge Clk); #1;
        ack_after = oAck;
    endtask

    int    lat;
    logic  tmo;
    tPADDR ppn;
    tPADDR lpa;
    logic  lwe;
    logic  aft;

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        n_cmp++; if (oAck !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", oAck); end
        n_cmp++; if (oLRU_WEnb !== 1'b0) begin n_bad++; $display("FAIL reset_lru_we: got %b expected 0", oLRU_WEnb); end
        n_cmp++; if (oBs_Req !== 1'b0) begin n_bad++; $display("FAIL reset_bs_req: got %b expected 0", oBs_Req); end
        n_cmp++; if (oPm_WEnb !== 1'b0) begin n_bad++; $display("FAIL reset_pm_we: got %b expected 0", oPm_WEnb); end
        n_cmp++;
        if ({oPpn, oLRU_PAddr, oPm_Addr, oPm_WData, oBs_Write, oBs_Addr, oBs_WData} !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: got ppn=%0d lru=%0d pma=%h pmd=%h bsw=%b bsa=%h bsd=%h expected all 0",
                     oPpn, oLRU_PAddr, oPm_Addr, oPm_WData, oBs_Write, oBs_Addr, oBs_WData);
        end
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_cold_miss();
        int err;
        logic [13:0] ea;
        clear_log();
        bs_max_delay = 0;
        do_req(8'h10, 1'b0, PAGE7, lat, tmo, ppn, lpa, lwe, aft);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL cold_timeout: got %b expected 0", tmo); end
        n_cmp++; if (lat != 66) begin n_bad++; $display("FAIL cold_latency: got %0d expected 66", lat); end
        n_cmp++; if (ppn !== PAGE7) begin n_bad++; $display("FAIL cold_ppn: got %0d expected 7", ppn); end
        n_cmp++; if (lpa !== PAGE7 || lwe !== 1'b1) begin n_bad++; $display("FAIL cold_lru: got %0d/%b expected 7/1", lpa, lwe); end
        n_cmp++; if (aft !== 1'b0) begin n_bad++; $display("FAIL cold_ack_pulse: got %b expected 0", aft); end
        n_cmp++; if (bs_addr_q.size() != 64) begin n_bad++; $display("FAIL cold_bs_count: got %0d expected 64", bs_addr_q.size()); end
        err = 0;
        if (bs_addr_q.size() < 64) err = 64;
        else for (int w = 0; w < 64; w++) begin
            ea = {8'h10, 6'(w)};
            if (bs_addr_q[w] !== ea || bs_wr_q[w] !== 1'b0) err++;
        end
        n_cmp++; if (err != 0) begin n_bad++; $display("FAIL cold_fill_order: got %0d bad words expected 0", err); end
        n_cmp++; if (pm[9'h1C0] !== bs_word(8'h10, 6'd0)) begin n_bad++; $display("FAIL cold_pm_w0: got %h expected %h", pm[9'h1C0], bs_word(8'h10, 6'd0)); end
        n_cmp++; if (pm[9'h1FF] !== bs_word(8'h10, 6'd63)) begin n_bad++; $display("FAIL cold_pm_w63: got %h expected %h", pm[9'h1FF], bs_word(8'h10, 6'd63)); end
    endtask

    task automatic test_hit_store();
        clear_log();
        do_req(8'h10, 1'b1, PAGE3, lat, tmo, ppn, lpa, lwe, aft);
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL hit_latency: got %0d expected 1", lat); end
        n_cmp++; if (ppn !== PAGE7) begin n_bad++; $display("FAIL hit_ppn: got %0d expected 7", ppn); end
        n_cmp++; if (lpa !== PAGE7 || lwe !== 1'b1) begin n_bad++; $display("FAIL hit_lru: got %0d/%b expected 7/1", lpa, lwe); end
        n_cmp++; if (aft !== 1'b0) begin n_bad++; $display("FAIL hit_ack_pulse: got %b expected 0", aft); end
        n_cmp++; if (bs_addr_q.size() != 0) begin n_bad++; $display("FAIL hit_bs_traffic: got %0d expected 0", bs_addr_q.size()); end
    endtask

    task automatic test_dirty_evict();
        int err_wb;
        int err_fill;
        logic [13:0] ea;
        clear_log();
        bs_max_delay = 5;
        do_req(8'h20, 1'b0, PAGE7, lat, tmo, ppn, lpa, lwe, aft);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL evict_timeout: got %b expected 0", tmo); end
        n_cmp++; if (bs_addr_q.size() != 128) begin n_bad++; $display("FAIL evict_bs_count: got %0d expected 128", bs_addr_q.size()); end
        err_wb = 0; err_fill = 0;
        if (bs_addr_q.size() < 128) begin
            err_wb = 64; err_fill = 64;
        end else begin
            for (int w = 0; w < 64; w++) begin
                ea = {8'h10, 6'(w)};
                if (bs_addr_q[w] !== ea || bs_wr_q[w] !== 1'b1 || bs_wd_q[w] !== bs_word(8'h10, 6'(w))) err_wb++;
                ea = {8'h20, 6'(w)};
                if (bs_addr_q[64+w] !== ea || bs_wr_q[64+w] !== 1'b0) err_fill++;
            end
        end
        n_cmp++; if (err_wb != 0) begin n_bad++; $display("FAIL evict_writeback: got %0d bad words expected 0", err_wb); end
        n_cmp++; if (err_fill != 0) begin n_bad++; $display("FAIL evict_fill: got %0d bad words expected 0", err_fill); end
        n_cmp++; if (bs_unstable != 0) begin n_bad++; $display("FAIL evict_req_stable: got %0d changes expected 0", bs_unstable); end
        n_cmp++; if (ppn !== PAGE7 || lpa !== PAGE7) begin n_bad++; $display("FAIL evict_ppn: got %0d/%0d expected 7/7", ppn, lpa); end
        n_cmp++; if (pm[9'h1C5] !== bs_word(8'h20, 6'd5)) begin n_bad++; $display("FAIL evict_pm_w5: got %h expected %h", pm[9'h1C5], bs_word(8'h20, 6'd5)); end
    endtask

    task automatic test_reset_mid_fill();
        logic reached;
        int err;
        logic [13:0] ea;
        clear_log();
        bs_max_delay = 2;
        reached = 1'b0;
        iVpn = 8'h30; iWr = 1'b0; iLRU_PAddr = PAGE6; iReq = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(posedge Clk); #2;
            if (bs_addr_q.size() >= 30) begin reached = 1'b1; break; end
        end
        n_cmp++; if (reached !== 1'b1) begin n_bad++; $display("FAIL midrst_reach_w30: got %0d words expected 30", bs_addr_q.size()); end
        Reset = 1'b1; iReq = 1'b0;
        @(posedge Clk); #1;
        n_cmp++;
        if ({oBs_Req, oPm_WEnb, oAck, oLRU_WEnb} !== 4'b0 || oBs_Addr !== '0) begin
            n_bad++;
            $display("FAIL midrst_outs: got req=%b pmwe=%b ack=%b lruwe=%b bsa=%h expected all 0",
                     oBs_Req, oPm_WEnb, oAck, oLRU_WEnb, oBs_Addr);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        clear_log();
        bs_max_delay = 0;
        do_req(8'h30, 1'b0, PAGE6, lat, tmo, ppn, lpa, lwe, aft);
        n_cmp++; if (lat != 66) begin n_bad++; $display("FAIL midrst_remiss_latency: got %0d expected 66", lat); end
        n_cmp++; if (ppn !== PAGE6) begin n_bad++; $display("FAIL midrst_remiss_ppn: got %0d expected 6", ppn); end
        err = 0;
        if (bs_addr_q.size() != 64) err = 64;
        else for (int w = 0; w < 64; w++) begin
            ea = {8'h30, 6'(w)};
            if (bs_addr_q[w] !== ea || bs_wr_q[w] !== 1'b0) err++;
        end
        n_cmp++; if (err != 0) begin n_bad++; $display("FAIL midrst_remiss_fill: got %0d bad words expected 0", err); end
    endtask

    task automatic test_back_to_back();
        bs_max_delay = 1;
        for (int i = 0; i < 8; i++) begin
            clear_log();
            do_req(8'h40 + 8'(i), 1'b0, tPADDR'(i), lat, tmo, ppn, lpa, lwe, aft);
            n_cmp++;
            if (ppn !== tPADDR'(i) || bs_addr_q.size() != 64) begin
                n_bad++;
                $display("FAIL b2b_fill_%0d: got ppn=%0d words=%0d expected ppn=%0d words=64", i, ppn, bs_addr_q.size(), i);
            end
        end
        clear_log();
        for (int i = 0; i < 8; i++) begin
            do_req(8'h40 + 8'(i), 1'b0, tPADDR'(7 - i), lat, tmo, ppn, lpa, lwe, aft);
            n_cmp++;
            if (lat != 1 || ppn !== tPADDR'(i) || lpa !== tPADDR'(i) || lwe !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_hit_%0d: got lat=%0d ppn=%0d lru=%0d we=%b expected lat=1 ppn=%0d lru=%0d we=1",
                         i, lat, ppn, lpa, lwe, i, i);
            end
        end
        n_cmp++; if (bs_addr_q.size() != 0) begin n_bad++; $display("FAIL b2b_hit_traffic: got %0d expected 0", bs_addr_q.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        iReq = 1'b0;
        iVpn = '0;
        iWr = 1'b0;
        iLRU_PAddr = PAGE0;
        @(posedge Clk); #1;
        test_reset();
        test_cold_miss();
        test_hit_store();
        test_dirty_evict();
        test_reset_mid_fill();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
